// File: rtl/axi4_slv_pkg.sv
// Shared AXI4 slave types, response codes and burst address helpers.
// WRAP support in next_addr/burst_err is compiled in only with AXI4_SLV_WRAP_EN.
package axi4_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_t;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [63:0] BOUNDARY_4K = 64'd4096;

    function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                              input logic [2:0]  size,
                                              input logic [7:0]  len,
                                              input burst_t      burst);
        logic [63:0] step;
        logic [63:0] incr;
`ifdef AXI4_SLV_WRAP_EN
        logic [63:0] wsize;
        logic [63:0] base;
`endif
        step = 64'd1 << size;
        incr = (addr & ~(step - 64'd1)) + step;
        next_addr = addr;
        case (burst)
            INCR: next_addr = incr;
`ifdef AXI4_SLV_WRAP_EN
            WRAP: begin
                wsize = ({56'd0, len} + 64'd1) << size;
                base  = addr & ~(wsize - 64'd1);
                next_addr = (incr == base + wsize) ? base : incr;
            end
`endif
            default: next_addr = addr;
        endcase
    endfunction

    function automatic logic burst_err(input logic [63:0] addr,
                                       input logic [2:0]  size,
                                       input logic [7:0]  len,
                                       input burst_t      burst,
                                       input logic [2:0]  max_size);
        logic [63:0] first;
        logic [63:0] last;
        logic        err;
        first = addr & ~((64'd1 << size) - 64'd1);
        last  = first + (({56'd0, len} + 64'd1) << size) - 64'd1;
        err   = (size > max_size);
        case (burst)
            INCR: if ((first & ~(BOUNDARY_4K - 64'd1)) != (last & ~(BOUNDARY_4K - 64'd1))) err = 1'b1;
`ifdef AXI4_SLV_WRAP_EN
            WRAP: if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || (addr != first))
                      err = 1'b1;
`else
            WRAP: err = 1'b1;
`endif
            RSVD: err = 1'b1;
            default: ;
        endcase
        burst_err = err;
    endfunction

endpackage

// File: rtl/axi4_be_ram.sv
// Synchronous dual-port RAM, byte write enables, registered read (old data on collision).
module axi4_be_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                    clk_sys,
    input  logic [DATA_WIDTH/8-1:0] we,
    input  logic [AW-1:0]           waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic                    re,
    input  logic [AW-1:0]           raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_sys) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
            if (we[i]) mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory with independent write/read FSMs; WRAP bursts need AXI4_SLV_WRAP_EN.
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting AWLEN+1 beats
//   W_RESP | BVALID high until BREADY
//   R_IDLE | ARREADY high, beat 0 read issued on AR handshake
//   R_DATA | issuing beats into a 2-entry output buffer until RLAST handshake
module axi4_slave_mem
    import axi4_slv_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 16,
    parameter int ID_WIDTH     = 4,
    parameter int MEMORY_DEPTH = 1024
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ID_WIDTH-1:0]     AWID,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WLAST,
    input  logic                    WVALID,
    output logic                    WREADY,
    output logic [ID_WIDTH-1:0]     BID,
    output logic [1:0]              BRESP,
    output logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ID_WIDTH-1:0]     ARID,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [7:0]              ARLEN,
    input  logic [2:0]              ARSIZE,
    input  logic [1:0]              ARBURST,
    input  logic                    ARVALID,
    output logic                    ARREADY,
    output logic [ID_WIDTH-1:0]     RID,
    output logic [DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]              RRESP,
    output logic                    RLAST,
    output logic                    RVALID,
    input  logic                    RREADY
);

    localparam int         STRB_W   = DATA_WIDTH / 8;
    localparam int         LSB      = $clog2(STRB_W);
    localparam int         MEM_AW   = $clog2(MEMORY_DEPTH);
    localparam logic [2:0] MAX_SIZE = 3'(LSB);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA} r_state_t;

    w_state_t              w_state;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [7:0]            aw_len_q;
    logic [2:0]            aw_size_q;
    burst_t                aw_burst_q;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_sticky;

    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_oob;
    logic                  w_last_beat;
    logic                  w_lmis;
    logic [STRB_W-1:0]     ram_we;

    assign w_word      = aw_addr_q >> LSB;
    assign w_oob       = 64'(w_word) >= 64'(MEMORY_DEPTH);
    assign w_last_beat = (w_cnt == 8'd0);
    assign w_lmis      = (WLAST != w_last_beat);
    assign ram_we      = (w_state == W_DATA && WVALID && !w_err && !w_oob) ? WSTRB : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state    <= W_IDLE;
            AWREADY    <= 1'b1;
            WREADY     <= 1'b0;
            BVALID     <= 1'b0;
            BRESP      <= RESP_OKAY;
            BID        <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= FIXED;
            w_cnt      <= '0;
            w_err      <= 1'b0;
            w_sticky   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: if (AWVALID && AWREADY) begin
                    BID        <= AWID;
                    aw_addr_q  <= AWADDR;
                    aw_len_q   <= AWLEN;
                    aw_size_q  <= AWSIZE;
                    aw_burst_q <= burst_t'(AWBURST);
                    w_cnt      <= AWLEN;
                    w_err      <= burst_err(64'(AWADDR), AWSIZE, AWLEN, burst_t'(AWBURST), MAX_SIZE);
                    w_sticky   <= 1'b0;
                    AWREADY    <= 1'b0;
                    WREADY     <= 1'b1;
                    w_state    <= W_DATA;
                end
                W_DATA: if (WVALID && WREADY) begin
                    aw_addr_q <= ADDR_WIDTH'(next_addr(64'(aw_addr_q), aw_size_q, aw_len_q, aw_burst_q));
                    w_cnt     <= w_cnt - 8'd1;
                    if (w_oob || w_lmis) w_sticky <= 1'b1;
                    // the beat count, not WLAST, ends the burst
                    if (w_last_beat) begin
                        WREADY  <= 1'b0;
                        BVALID  <= 1'b1;
                        BRESP   <= (w_err || w_sticky || w_oob || w_lmis) ? RESP_SLVERR : RESP_OKAY;
                        w_state <= W_RESP;
                    end
                end
                W_RESP: if (BREADY) begin
                    BVALID  <= 1'b0;
                    AWREADY <= 1'b1;
                    w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    r_state_t              r_state;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [7:0]            ar_len_q;
    logic [2:0]            ar_size_q;
    burst_t                ar_burst_q;
    logic                  r_err;
    logic [7:0]            r_rem;
    logic                  pend;
    logic                  pend_zero;
    logic                  pend_last;
    logic                  s1_v;
    logic [DATA_WIDTH-1:0] s1_data;
    logic [1:0]            s1_resp;
    logic                  s1_last;

    logic                  ar_hs;
    logic                  r_pop;
    logic                  ar_err_in;
    logic                  credit_ok;
    logic                  r_issue_next;
    logic                  issue;
    logic [ADDR_WIDTH-1:0] iss_addr;
    logic [7:0]            iss_len;
    logic [2:0]            iss_size;
    burst_t                iss_burst;
    logic [ADDR_WIDTH-1:0] iss_word;
    logic                  iss_bad;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            push_resp;

    assign ar_hs     = ARVALID && ARREADY;
    assign r_pop     = RVALID && RREADY;
    assign ar_err_in = burst_err(64'(ARADDR), ARSIZE, ARLEN, burst_t'(ARBURST), MAX_SIZE);
    // a new beat may launch only if it will find a free buffer slot when it lands
    assign credit_ok = ({1'b0, RVALID} + {1'b0, s1_v} + {1'b0, pend}) <= (2'd1 + {1'b0, r_pop});
    assign r_issue_next = (r_state == R_DATA) && (r_rem != 8'd0) && credit_ok;
    assign issue     = ar_hs || r_issue_next;
    assign iss_addr  = ar_hs ? ARADDR : ar_addr_q;
    assign iss_len   = ar_hs ? ARLEN : ar_len_q;
    assign iss_size  = ar_hs ? ARSIZE : ar_size_q;
    assign iss_burst = ar_hs ? burst_t'(ARBURST) : ar_burst_q;
    assign iss_word  = iss_addr >> LSB;
    assign iss_bad   = (ar_hs ? ar_err_in : r_err) || (64'(iss_word) >= 64'(MEMORY_DEPTH));
    assign push_data = pend_zero ? '0 : ram_rdata;
    assign push_resp = pend_zero ? RESP_SLVERR : RESP_OKAY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state    <= R_IDLE;
            ARREADY    <= 1'b1;
            RID        <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= FIXED;
            r_err      <= 1'b0;
            r_rem      <= '0;
            pend       <= 1'b0;
            pend_zero  <= 1'b0;
            pend_last  <= 1'b0;
            s1_v       <= 1'b0;
            s1_data    <= '0;
            s1_resp    <= RESP_OKAY;
            s1_last    <= 1'b0;
            RVALID     <= 1'b0;
            RDATA      <= '0;
            RRESP      <= RESP_OKAY;
            RLAST      <= 1'b0;
        end else begin
            pend <= issue;
            if (issue) begin
                pend_zero <= iss_bad;
                pend_last <= ar_hs ? (ARLEN == 8'd0) : (r_rem == 8'd1);
                ar_addr_q <= ADDR_WIDTH'(next_addr(64'(iss_addr), iss_size, iss_len, iss_burst));
            end
            if (ar_hs) begin
                RID        <= ARID;
                ar_len_q   <= ARLEN;
                ar_size_q  <= ARSIZE;
                ar_burst_q <= burst_t'(ARBURST);
                r_err      <= ar_err_in;
                r_rem      <= ARLEN;
                ARREADY    <= 1'b0;
                r_state    <= R_DATA;
            end else if (r_issue_next) begin
                r_rem <= r_rem - 8'd1;
            end
            if (r_state == R_DATA && r_pop && RLAST) begin
                ARREADY <= 1'b1;
                r_state <= R_IDLE;
            end

            if (!RVALID || r_pop) begin
                if (s1_v) begin
                    RVALID  <= 1'b1;
                    RDATA   <= s1_data;
                    RRESP   <= s1_resp;
                    RLAST   <= s1_last;
                    s1_v    <= pend;
                    s1_data <= push_data;
                    s1_resp <= push_resp;
                    s1_last <= pend_last;
                end else if (pend) begin
                    RVALID <= 1'b1;
                    RDATA  <= push_data;
                    RRESP  <= push_resp;
                    RLAST  <= pend_last;
                end else begin
                    RVALID <= 1'b0;
                    RLAST  <= 1'b0;
                end
            end else if (pend) begin
                s1_v    <= 1'b1;
                s1_data <= push_data;
                s1_resp <= push_resp;
                s1_last <= pend_last;
            end
        end
    end

    axi4_be_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH),
        .AW         (MEM_AW)
    ) u_ram (
        .clk_sys (ACLK),
        .we      (ram_we),
        .waddr   (MEM_AW'(w_word)),
        .wdata   (WDATA),
        .re      (issue && !iss_bad),
        .raddr   (MEM_AW'(iss_word)),
        .rdata   (ram_rdata)
    );

endmodule
